// File: rtl/edsac_order_pkg.sv
// rtl/edsac_order_pkg.sv - EDSAC short-order field positions, function codes and c-line indices
package edsac_order_pkg;

    localparam int ORDER_W = 17;
    localparam int ADDR_W  = 10;
    localparam int FUNC_W  = 5;

    // Bit positions within the serial order, in arrival order (LSB first)
    localparam int LEN_BIT   = 0;
    localparam int ADDR_LSB  = 1;
    localparam int ADDR_MSB  = 10;
    localparam int SPARE_BIT = 11;
    localparam int FUNC_LSB  = 12;
    localparam int FUNC_MSB  = 16;

    // Teleprinter codes of the function letters
    localparam logic [4:0] FN_E = 5'd3;
    localparam logic [4:0] FN_R = 5'd4;
    localparam logic [4:0] FN_T = 5'd5;
    localparam logic [4:0] FN_Y = 5'd6;
    localparam logic [4:0] FN_U = 5'd7;
    localparam logic [4:0] FN_O = 5'd9;
    localparam logic [4:0] FN_S = 5'd12;
    localparam logic [4:0] FN_Z = 5'd13;
    localparam logic [4:0] FN_H = 5'd21;
    localparam logic [4:0] FN_N = 5'd22;
    localparam logic [4:0] FN_L = 5'd25;
    localparam logic [4:0] FN_X = 5'd26;
    localparam logic [4:0] FN_G = 5'd27;
    localparam logic [4:0] FN_A = 5'd28;
    localparam logic [4:0] FN_C = 5'd30;
    localparam logic [4:0] FN_V = 5'd31;

    // Positions of each decoded line inside the c-line vector
    localparam int CL_C1   = 0;
    localparam int CL_C2   = 1;
    localparam int CL_C3   = 2;
    localparam int CL_C4   = 3;
    localparam int CL_C7   = 4;
    localparam int CL_C8   = 5;
    localparam int CL_C9   = 6;
    localparam int CL_C10  = 7;
    localparam int CL_C18  = 8;
    localparam int CL_C19  = 9;
    localparam int CL_C21  = 10;
    localparam int CL_C25  = 11;
    localparam int CL_STOP = 12;
    localparam int CL_W    = 13;

    typedef logic [CL_W-1:0] cline_t;

endpackage

// File: rtl/order_decode.sv
// rtl/order_decode.sv - combinational map from function code to c-line vector
module order_decode
    import edsac_order_pkg::*;
(
    input  logic [FUNC_W-1:0] i_func,
    output cline_t            o_clines
);

    // Unlisted codes (F, I and the rest) are no-ops: every line stays low
    always_comb begin
        o_clines = '0;
        case (i_func)
            FN_A: begin
                o_clines[CL_C1] = 1'b1;
                o_clines[CL_C2] = 1'b1;
            end
            FN_S: begin
                o_clines[CL_C1] = 1'b1;
                o_clines[CL_C3] = 1'b1;
            end
            FN_C: begin
                o_clines[CL_C1] = 1'b1;
                o_clines[CL_C4] = 1'b1;
            end
            FN_V, FN_N: o_clines[CL_C1]   = 1'b1;
            FN_R:       o_clines[CL_C7]   = 1'b1;
            FN_L:       o_clines[CL_C8]   = 1'b1;
            FN_X, FN_Y: o_clines[CL_C9]   = 1'b1;
            FN_G:       o_clines[CL_C10]  = 1'b1;
            FN_H:       o_clines[CL_C18]  = 1'b1;
            FN_T, FN_U: o_clines[CL_C19]  = 1'b1;
            FN_O:       o_clines[CL_C21]  = 1'b1;
            FN_E:       o_clines[CL_C25]  = 1'b1;
            FN_Z:       o_clines[CL_STOP] = 1'b1;
            default:    o_clines = '0;
        endcase
    end

endmodule

// File: rtl/order_coder.sv
// rtl/order_coder.sv - serial short-order deserialiser, latch and c-line decoder
module order_coder
    import edsac_order_pkg::*;
#(
    parameter int ORDER_W = edsac_order_pkg::ORDER_W,
    parameter int ADDR_W  = edsac_order_pkg::ADDR_W,
    parameter int FUNC_W  = edsac_order_pkg::FUNC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mib,
    input  logic              d0,
    input  logic              d17,
    input  logic              g12,
    output logic              c1,
    output logic              c2,
    output logic              c3,
    output logic              c4,
    output logic              c7,
    output logic              c8,
    output logic              c9,
    output logic              c10,
    output logic              c18,
    output logic              c19,
    output logic              c21,
    output logic              c25,
    output logic              c_stop,
    output logic              f1_neg,
    output logic [ADDR_W-1:0] addr,
    output logic              order_valid,
    output logic              frame_err
);

    localparam int CNT_W  = $clog2(ORDER_W + 1);
    localparam int AIDX_W = $clog2(ADDR_W);
    localparam int FIDX_W = $clog2(FUNC_W);

    localparam logic [CNT_W-1:0] K_FULL     = CNT_W'(ORDER_W);
    localparam logic [CNT_W-1:0] K_LEN      = CNT_W'(LEN_BIT);
    localparam logic [CNT_W-1:0] K_ADDR_LSB = CNT_W'(ADDR_LSB);
    localparam logic [CNT_W-1:0] K_ADDR_MSB = CNT_W'(ADDR_MSB);
    localparam logic [CNT_W-1:0] K_FUNC_LSB = CNT_W'(FUNC_LSB);

    // Incoming order is split by field as it arrives; the spare bit is never stored
    logic [CNT_W-1:0]  r_count;
    logic              r_len_sh;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [FUNC_W-1:0] r_func_sh;

    logic [AIDX_W-1:0] w_addr_idx;
    logic [FIDX_W-1:0] w_func_idx;
    logic              w_full;
    cline_t            w_clines;

    cline_t            r_clines;
    logic              r_f1_neg;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_frame_err;

    assign w_addr_idx = AIDX_W'(r_count - K_ADDR_LSB);
    assign w_func_idx = FIDX_W'(r_count - K_FUNC_LSB);
    assign w_full     = (r_count == K_FULL);

    order_decode u_decode (
        .i_func   (r_func_sh),
        .o_clines (w_clines)
    );

    // Deserialise mib under g12; d17 beats d0, d0 restarts the frame, count saturates at 17
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_len_sh  <= 1'b0;
            r_addr_sh <= '0;
            r_func_sh <= '0;
        end else if (g12 && !d17) begin
            if (d0) begin
                r_count  <= CNT_W'(1);
                r_len_sh <= mib;
            end else if (!w_full) begin
                if (r_count == K_LEN) begin
                    r_len_sh <= mib;
                end else if (r_count <= K_ADDR_MSB) begin
                    r_addr_sh[w_addr_idx] <= mib;
                end else if (r_count >= K_FUNC_LSB) begin
                    r_func_sh[w_func_idx] <= mib;
                end
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Latch the decoded order on d17 only when exactly 17 bits were captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clines    <= '0;
            r_f1_neg    <= 1'b1;
            r_addr      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (g12 && d17) begin
                if (w_full) begin
                    r_clines <= w_clines;
                    r_f1_neg <= ~r_len_sh;
                    r_addr   <= r_addr_sh;
                    r_valid  <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign c1          = r_clines[CL_C1];
    assign c2          = r_clines[CL_C2];
    assign c3          = r_clines[CL_C3];
    assign c4          = r_clines[CL_C4];
    assign c7          = r_clines[CL_C7];
    assign c8          = r_clines[CL_C8];
    assign c9          = r_clines[CL_C9];
    assign c10         = r_clines[CL_C10];
    assign c18         = r_clines[CL_C18];
    assign c19         = r_clines[CL_C19];
    assign c21         = r_clines[CL_C21];
    assign c25         = r_clines[CL_C25];
    assign c_stop      = r_clines[CL_STOP];
    assign f1_neg      = r_f1_neg;
    assign addr        = r_addr;
    assign order_valid = r_valid;
    assign frame_err   = r_frame_err;

endmodule
